// File: rtl/jtpopeye_objdma_if.sv
// rtl/jtpopeye_objdma_if.sv - CPU bus request/ack, source RAM and destination bank signals of the object DMA
interface jtpopeye_objdma_if #(
  parameter int AW    = 10,
  parameter int DW    = 8,
  parameter int BANKS = 4,
  parameter int LW    = 8
);
  logic             busak_n;
  logic [DW-1:0]    din;
  logic             busrq_n;
  logic [AW-1:0]    addr;
  logic             addr_oe;
  logic [DW-1:0]    dm_dout;
  logic [LW-1:0]    dm_addr;
  logic [BANKS-1:0] dm_cs;

  modport master (
    input  busak_n, din,
    output busrq_n, addr, addr_oe, dm_dout, dm_addr, dm_cs
  );

  modport slave (
    output busak_n, din,
    input  busrq_n, addr, addr_oe, dm_dout, dm_addr, dm_cs
  );
endinterface

// File: rtl/jtpopeye_objdma.sv
// rtl/jtpopeye_objdma.sv - object RAM DMA: on vblank, grabs the CPU bus and copies LEN*BANKS words
// into BANKS destination banks, two cen cycles (ADDR, WRITE) per word.
module jtpopeye_objdma #(
  parameter int AW    = 10,
  parameter int DW    = 8,
  parameter int BANKS = 4,
  parameter int LEN   = 256,
  parameter int LW    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic              vb,
  input  logic              enable,
  input  logic [AW-1:0]     base,
  output logic              busy,
  output logic              done,
  jtpopeye_objdma_if.master bus
);
  localparam int            KW     = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(BANKS - 1);
  localparam logic [LW-1:0] E_LAST = LW'(LEN - 1);

  typedef enum logic [2:0] {IDLE, REQ, ADDR, WRITE, REL} state_t;

  state_t           r_state;
  logic             r_vb;
  logic             r_armed;
  logic             r_abort;
  logic [AW-1:0]    r_base;
  logic [LW-1:0]    r_e;
  logic [KW-1:0]    r_k;
  logic             r_busrq_n;
  logic [AW-1:0]    r_addr;
  logic             r_addr_oe;
  logic [DW-1:0]    r_dm_dout;
  logic [LW-1:0]    r_dm_addr;
  logic [BANKS-1:0] r_dm_cs;
  logic             r_busy;
  logic             r_done;

  logic             w_trig;
  logic             w_last;
  logic [KW-1:0]    w_k_nxt;
  logic [LW-1:0]    w_e_nxt;
  logic [AW-1:0]    w_addr_nxt;

  // r_armed needs one sampled vb=0 after reset, so vb held high across reset never counts as an edge
  assign w_trig     = vb & ~r_vb & r_armed & enable;
  assign w_last     = (r_e == E_LAST) && (r_k == K_LAST);
  assign w_k_nxt    = (r_k == K_LAST) ? '0 : r_k + 1'b1;
  assign w_e_nxt    = (r_k == K_LAST) ? r_e + 1'b1 : r_e;
  assign w_addr_nxt = r_base + AW'(w_e_nxt) * AW'(BANKS) + AW'(w_k_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_vb      <= 1'b0;
      r_armed   <= 1'b0;
      r_abort   <= 1'b0;
      r_base    <= '0;
      r_e       <= '0;
      r_k       <= '0;
      r_busrq_n <= 1'b1;
      r_addr    <= '0;
      r_addr_oe <= 1'b0;
      r_dm_dout <= '0;
      r_dm_addr <= '0;
      r_dm_cs   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (cen) begin
      r_vb    <= vb;
      r_armed <= r_armed | ~vb;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_trig) begin
            r_base    <= base;
            r_e       <= '0;
            r_k       <= '0;
            r_abort   <= 1'b0;
            r_busrq_n <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= REQ;
          end
        end
        REQ: begin
          if (!enable) begin
            r_busrq_n <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else if (!bus.busak_n) begin
            r_addr    <= r_base;
            r_addr_oe <= 1'b1;
            r_state   <= ADDR;
          end
        end
        ADDR: begin
          if (bus.busak_n) begin
            r_busrq_n <= 1'b1;
            r_addr_oe <= 1'b0;
            r_state   <= REL;
          end else begin
            r_dm_dout <= bus.din;
            r_dm_addr <= r_e;
            r_dm_cs   <= BANKS'(1) << r_k;
            r_abort   <= ~enable;
            r_state   <= WRITE;
          end
        end
        WRITE: begin
          r_dm_cs <= '0;
          // an enable drop seen in ADDR still lets this word finish before releasing
          if (bus.busak_n || !enable || r_abort || w_last) begin
            r_busrq_n <= 1'b1;
            r_addr_oe <= 1'b0;
            r_state   <= REL;
          end else begin
            r_e     <= w_e_nxt;
            r_k     <= w_k_nxt;
            r_addr  <= w_addr_nxt;
            r_state <= ADDR;
          end
        end
        REL: begin
          if (bus.busak_n) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busrq_n = r_busrq_n;
  assign bus.addr    = r_addr;
  assign bus.addr_oe = r_addr_oe;
  assign bus.dm_dout = r_dm_dout;
  assign bus.dm_addr = r_dm_addr;
  assign bus.dm_cs   = r_dm_cs;
  assign busy        = r_busy;
  assign done        = r_done;
endmodule

// File: tb/tb_jtpopeye_objdma.sv
// tb/tb_jtpopeye_objdma.sv - directed bench for jtpopeye_objdma with a word-list scoreboard
module tb_jtpopeye_objdma;
  localparam int AW = 10, DW = 8, BANKS = 4, LEN = 256, LW = 8;
  localparam int NW = LEN * BANKS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cen = 1'b0;
  logic          vb = 1'b1;
  logic          enable = 1'b1;
  logic [AW-1:0] base = '0;
  logic          busy;
  logic          done;

  jtpopeye_objdma_if #(.AW(AW), .DW(DW), .BANKS(BANKS), .LW(LW)) bus();

  jtpopeye_objdma #(.AW(AW), .DW(DW), .BANKS(BANKS), .LEN(LEN), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .vb(vb), .enable(enable),
    .base(base), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int e; int k; } word_t;
  word_t exp_q[$];
  word_t mon_w;

  int checks = 0, failures = 0;
  int cen_edges = 0, clk_cnt = 0, cen_mode = 0;
  int wr_cnt = 0, adr_cnt = 0, done_cnt = 0, low_cnt = 0;
  int fw0 = 0, fa0 = 0, d0 = 0, l0 = 0, ack_release = 0;
  logic ack_pipe = 1'b1;
  logic [DW-1:0] obs_data [NW];
  logic [AW-1:0] obs_addr [NW];

  function automatic logic [DW-1:0] mem_f(input int a);
    return DW'((a * 37 + 11) & 255);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // compare process plus source RAM / bus-ack / cen drivers, all away from the active edge
  always @(negedge clk) begin
    if (cen) begin
      cen_edges++;
      if (rst_n) begin
        chk("cs_onehot_or_zero", $countones(bus.dm_cs) <= 1, 1);
        if (bus.addr_oe) chk("no_oe_without_ack", bus.busak_n, 0);
        if (!bus.busrq_n) low_cnt++;
        if (done) done_cnt++;
        if (bus.dm_cs != '0) begin
          chk("oe_during_write", bus.addr_oe, 1);
          chk("write_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            mon_w = exp_q.pop_front();
            chk("dm_addr", bus.dm_addr, mon_w.e);
            chk("dm_cs", bus.dm_cs, 1 << mon_w.k);
            chk("dm_dout", bus.dm_dout, mem_f(mon_w.addr));
          end
          if (wr_cnt - fw0 < NW) obs_data[wr_cnt - fw0] = bus.dm_dout;
          wr_cnt++;
        end else if (bus.addr_oe) begin
          if (exp_q.size() > 0) chk("src_addr", bus.addr, exp_q[0].addr);
          if (adr_cnt - fa0 < NW) obs_addr[adr_cnt - fa0] = bus.addr;
          adr_cnt++;
        end
      end
    end
    if (!rst_n) begin
      ack_pipe    = 1'b1;
      bus.busak_n = 1'b1;
    end else if (cen) begin
      bus.busak_n = (cen_edges < ack_release) ? 1'b1 : ack_pipe;
      ack_pipe    = bus.busrq_n;
    end
    bus.din = mem_f(int'(bus.addr));
    if (cen_mode == 0) cen = (clk_cnt % 3 == 2);
    else cen = ($urandom_range(0, 3) == 0);
    clk_cnt++;
  end

  task automatic wait_cen(input int n);
    int s, g;
    s = cen_edges;
    g = 0;
    while (cen_edges < s + n && g < 100000) begin @(negedge clk); g++; end
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_busrq_n"}, bus.busrq_n, 1);
    chk({nm, "_addr_oe"}, bus.addr_oe, 0);
    chk({nm, "_addr"}, bus.addr, 0);
    chk({nm, "_dm_cs"}, bus.dm_cs, 0);
    chk({nm, "_dm_dout"}, bus.dm_dout, 0);
    chk({nm, "_dm_addr"}, bus.dm_addr, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  task automatic trigger(input logic [AW-1:0] b, input int nw, input int hold);
    vb = 1'b0;
    wait_cen(2);
    base = b;
    for (int w = 0; w < nw; w++)
      exp_q.push_back('{addr: (int'(b) + w) % (1 << AW), e: w / BANKS, k: w % BANKS});
    fw0 = wr_cnt; fa0 = adr_cnt; d0 = done_cnt; l0 = low_cnt;
    ack_release = cen_edges + hold;
    vb = 1'b1;
  endtask

  task automatic wait_writes(input string nm, input int n);
    int g;
    g = 0;
    while (wr_cnt - fw0 < n && g < 20000) begin @(negedge clk); g++; end
    chk({nm, "_writes_reached"}, wr_cnt - fw0 >= n, 1);
  endtask

  task automatic finish_frame(input string nm, input int nw);
    int g;
    g = 0;
    while (done_cnt == d0 && g < 40000) begin @(negedge clk); g++; end
    chk({nm, "_done_seen"}, done_cnt != d0, 1);
    wait_cen(3);
    chk({nm, "_writes"}, wr_cnt - fw0, nw);
    chk({nm, "_done_pulses"}, done_cnt - d0, 1);
    chk({nm, "_model_drained"}, exp_q.size(), 0);
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_idle_busrq"}, bus.busrq_n, 1);
  endtask

  initial begin
    repeat (6) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    wait_cen(30);
    chk("vb_held_no_trigger_busy", busy, 0);
    chk("vb_held_no_trigger_busrq", bus.busrq_n, 1);

    // full transfer from 0, with a second vb edge injected while busy
    trigger(10'h000, NW, 0);
    wait_writes("f0_mid", 200);
    vb = 1'b0;
    wait_cen(3);
    vb = 1'b1;
    finish_frame("f0", NW);
    chk("f0_busrq_low_cen", low_cnt - l0, 2050);
    chk("f0_lit_e5_b2", obs_data[22], 8'h39);
    chk("f0_lit_last", obs_data[1023], 8'hE6);

    // source address wraps past 0x3FF
    trigger(10'h3FE, NW, 0);
    finish_frame("wrap", NW);
    chk("wrap_addr0", obs_addr[0], 10'h3FE);
    chk("wrap_addr1", obs_addr[1], 10'h3FF);
    chk("wrap_addr2", obs_addr[2], 10'h000);
    chk("wrap_addr3", obs_addr[3], 10'h001);
    chk("wrap_data0", obs_data[0], 8'hC1);
    chk("wrap_data2", obs_data[2], 8'h0B);

    // acknowledge withheld for 50 cen
    trigger(10'h155, NW, 50);
    finish_frame("hold", NW);
    chk("hold_lengthens_request", (low_cnt - l0) >= 2090, 1);

    // enable dropped while still requesting: back to idle, no done
    trigger(10'h000, 0, 40);
    wait_cen(6);
    chk("req_abort_busy_before", busy, 1);
    chk("req_abort_busrq_before", bus.busrq_n, 0);
    enable = 1'b0;
    wait_cen(3);
    chk("req_abort_busy", busy, 0);
    chk("req_abort_busrq", bus.busrq_n, 1);
    wait_cen(45);
    chk("req_abort_no_done", done_cnt - d0, 0);
    chk("req_abort_no_writes", wr_cnt - fw0, 0);
    enable = 1'b1;

    // enable dropped during the third WRITE
    trigger(10'h040, 3, 0);
    wait_writes("abort", 3);
    enable = 1'b0;
    finish_frame("abort", 3);
    enable = 1'b1;

    // reset in the middle of a transfer, vb kept high through release
    trigger(10'h100, NW, 0);
    wait_writes("rst_mid", 100);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_mid");
    exp_q.delete();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    fw0 = wr_cnt;
    wait_cen(30);
    chk("rst_mid_stays_idle", busy, 0);
    chk("rst_mid_no_busrq", bus.busrq_n, 1);
    chk("rst_mid_no_writes", wr_cnt - fw0, 0);

    // random cen gaps over two frames
    cen_mode = 1;
    trigger(AW'($urandom_range(0, 1023)), NW, 0);
    finish_frame("rnd0", NW);
    trigger(AW'($urandom_range(0, 1023)), NW, 0);
    finish_frame("rnd1", NW);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jtpopeye_objdma.md
JTPOPEYE_OBJDMA -- requirements
Module: jtpopeye_objdma

Interface
REQ-001 Parameter AW, default 10: source address width.
REQ-002 Parameter DW, default 8: data width.
REQ-003 Parameter BANKS, default 4: destination banks, one chip select each.
REQ-004 Parameter LEN, default 256: entries per transfer; one entry is BANKS words; LEN*BANKS SHALL not exceed 2^AW.
REQ-005 Parameter LW, default 8: entry index width, with 2^LW >= LEN.
REQ-006 Ports:
  clk       in   1        system clock
  rst_n     in   1        asynchronous active-low reset
  cen       in   1        CPU-rate clock enable; all state advances only when cen=1
  vb        in   1        vertical blank
  enable    in   1        transfer enable
  base      in   AW       source start address, sampled at trigger
  busak_n   in   1        CPU bus acknowledge, active low
  din       in   DW       source RAM read data
  busrq_n   out  1        CPU bus request, active low
  addr      out  AW       source address
  addr_oe   out  1        addr valid / bus driven
  dm_dout   out  DW       data to destination banks
  dm_addr   out  LW       entry index within destination banks
  dm_cs     out  BANKS    one-hot destination write strobe
  busy      out  1        transfer in progress
  done      out  1        one-cen-cycle completion pulse

Function
REQ-007 Trigger: rising edge of vb, detected on cen cycles against a registered copy of vb, with enable=1; base latched in the same cycle.
REQ-008 A trigger that arrives while busy=1 SHALL be ignored, not queued.
REQ-009 FSM states: IDLE, REQ, ADDR, WRITE, REL.
REQ-010 IDLE -> REQ on trigger; in REQ, busrq_n=0 and busy=1.
REQ-011 REQ -> ADDR on the first cen cycle where busak_n=0 is sampled; there is no timeout.
REQ-012 ADDR (one cen cycle): addr=base+e*BANKS+k, addr_oe=1, dm_cs=0, where e = entry index and k = bank index.
REQ-013 WRITE (one cen cycle): dm_dout=din as sampled at the end of ADDR, dm_addr=e, dm_cs=1<<k, addr_oe=1.
REQ-014 Ordering: k runs 0..BANKS-1 within an entry, then e increments and k returns to 0; each word takes exactly 2 cen cycles, and a full transfer takes 2*LEN*BANKS cen cycles of bus ownership.
REQ-015 Address arithmetic is modulo 2^AW: base+offset wraps silently past all-ones.
REQ-016 After the WRITE of e=LEN-1, k=BANKS-1, go to REL: busrq_n=1, addr_oe=0, dm_cs=0.
REQ-017 REL -> IDLE on the first cen cycle with busak_n=1 sampled; done=1 for exactly that cen cycle; busy=0 from IDLE onward.
REQ-018 Abort: enable=0 sampled during ADDR or WRITE completes the current word's WRITE and then enters REL; done SHALL still pulse.
REQ-019 enable=0 during REQ returns to IDLE immediately, with busrq_n=1 and no done pulse.
REQ-020 dm_cs SHALL never have more than one bit set, and SHALL be 0 outside WRITE.
REQ-021 addr_oe=0 whenever busak_n=1 or the state is IDLE/REQ/REL; the block never drives the bus without acknowledge.
REQ-022 busak_n rising during ADDR/WRITE (bus lost) SHALL force REL at once, with no further dm_cs and a done pulse.
REQ-023 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-024 rst_n=0 SHALL asynchronously force: state IDLE, busrq_n=1, addr_oe=0, addr=0, dm_cs=0, dm_dout=0, dm_addr=0, busy=0, done=0, registered vb=0, counters=0.
REQ-025 Reset mid-transfer abandons the transfer; after release, nothing happens until a new vb rising edge.
REQ-026 vb=1 held through reset release SHALL NOT trigger a transfer; a 0->1 transition is required.

Verification
REQ-027 Defaults, base=0x000, cen every 3rd clk, busak_n=busrq_n delayed one cen: vb 0->1 -> 1024 dm_cs pulses; bank k gets source words 4e+k at dm_addr=e; busrq_n low for 2048+2 cen; exactly one done pulse.
REQ-028 base=0x3FE, LEN=2 -> source addresses 0x3FE,0x3FF,0x000,...,0x005 in order (wrap).
REQ-029 busak_n held high for 50 cen after the request -> no addr_oe and no dm_cs during the wait; the transfer then completes normally.
REQ-030 enable dropped on the 3rd WRITE -> exactly 3 dm_cs pulses (banks 0,1,2 of entry 0), then bus released and done pulses.
REQ-031 Second vb edge while busy -> ignored, exactly 1024 writes total; rst_n pulsed low mid-transfer -> all outputs return to reset values within the same clk.
REQ-032 Multi-frame run with random cen gaps -> dm_cs is always one-hot-or-zero, and addr_oe is never 1 while busak_n=1.
